key_device: RTL and testbench
=============================

// Module: key_device
// PURPOSE
//  Memory-mapped input device for the four push-buttons on the shared aBus/dBus I/O bus.
//  Synchronises and debounces the raw keys, then presents the debounced state as KDATA.
//  Holds a status register, KCTRL, with sticky Ready/Overrun flags so software can poll for changes.
//  Bus peer of the LEDR/LEDG/HEX output devices: it supplies the input data that software forwards to them.
// PARAMETERS
//  ABUS_WIDTH       32     address bus width
//  DBUS_WIDTH       32     data bus width
//  NKEYS            4      number of keys (<=16)
//  DEBOUNCE_CYCLES  10000  consecutive stable cycles required before a key change is accepted (>=2)
//  KDATA_ADDR       32'hF0000010  address of the data register (read-only)
//  KCTRL_ADDR       32'hF0000110  address of the control/status register
// PORTS
//  clk    in     1           system clock; sole clock domain
//  reset  in     1           synchronous, active-high reset
//  aBus   in     ABUS_WIDTH  bus address
//  dBus   inout  DBUS_WIDTH  bus data; driven only on a matching read, otherwise 'z
//  wrtEn  in     1           1 = bus write, 0 = bus read
//  key    in     NKEYS       raw keys, active-low (0 = pressed), asynchronous
//  irq    out    1           interrupt request; present only with KEY_IRQ_EN
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset); all state updates on posedge clk.
//  Reset values: sync flops = all 1 (released), kdata=0, debounce counters=0, Ready=0, Overrun=0, IE=0, irq=0.
//  Reset mid-debounce: discards any partial count; the first post-reset sample restarts counting.
//  Sync: two-flop synchroniser per key; synced value inverted so that pressed = 1.
//  Debounce, per key:
//   - If synced == kdata[i], cnt=0.
//   - Otherwise cnt increments.
//   - When cnt == DEBOUNCE_CYCLES-1 and the value still differs, kdata[i] <= synced and cnt <= 0.
//   - Latency from a stable raw edge to kdata = 2 + DEBOUNCE_CYCLES clocks.
//   - A glitch shorter than DEBOUNCE_CYCLES never reaches kdata.
//  change = any kdata bit updates this cycle.
//  KDATA read (aBus==KDATA_ADDR && !wrtEn):
//   - dBus = {zero-extended, kdata} combinationally.
//   - Clears Ready at the next edge.
//   - Writes to KDATA are ignored.
//  KCTRL read: dBus = {..0, IE@bit8, 0, 0, Overrun@bit2, 0, Ready@bit0}, all other bits 0.
//  KCTRL write (aBus==KCTRL_ADDR && wrtEn):
//   - A 0 written to bit0 clears Ready; a 0 written to bit2 clears Overrun; writing 1 to either is ignored.
//   - Bit8 loads IE.
//  Flag update priority (one edge):
//   - Overrun is set if change && Ready_old && !clear_ready; otherwise the written value applies.
//   - Ready is set by change; set wins over a KDATA read or KCTRL clear in the same cycle.
//  Multi-cycle reads are allowed; they clear Ready once and hold it clear until the next change.
//  Any other address: dBus = 'z and no side effects. The address decode is a full-width compare.
// CONFIGURATION
//  KEY_IRQ_EN defined:
//   - irq = registered (Ready & IE), one cycle behind the flags; IE is readable and writable at bit8.
//  KEY_IRQ_EN undefined:
//   - No irq port and no IE flop; bit8 reads 0 and writes to it are ignored.
// STRUCTURE
//  Shared package io_dev_pkg:
//   - Address constants (KDATA_ADDR, KCTRL_ADDR, plus the existing HEX/LEDR/LEDG addresses).
//   - KCTRL bit-index constants (READY_BIT=0, OVR_BIT=2, IE_BIT=8).
//  Sub-module key_debounce:
//   - Handles one key: synchroniser, counter of width $clog2(DEBOUNCE_CYCLES), stable-output flop, 'changed' pulse.
//   - Instantiated NKEYS times via generate.
//  The top level holds the bus decode, the flags and the tri-state drive.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset, then read KDATA and KCTRL -> 0x0 and 0x0; with no read issued, dBus stays 'z.
//  2. Drive key=4'b1110 steady -> kdata=0x1 exactly 6 clocks later, Ready=1; KDATA read -> 0x1; next KCTRL read -> 0x0.
//  3. Pulse key[1] low for 3 clocks -> kdata unchanged and Ready stays 0.
//  4. Press key0; leave Ready unread; release key0 -> KCTRL=0x5 (Ready+Overrun); write KCTRL 0x0 -> 0x0.
//  5. Debounce completes in the same cycle as a KDATA read -> Ready=1 afterwards, Overrun=0.
//  6. KEY_IRQ_EN: write KCTRL 0x100, press key2 -> irq=1 one clock after Ready; read KDATA -> irq=0 next cycle.
//     Assert reset mid-debounce -> all flags 0 and counters cleared.

Source files
------------

// File: rtl/io_dev_pkg.sv
// Shared constants for the memory-mapped I/O devices on the aBus/dBus bus:
// device addresses and the key-device status register bit positions.
package io_dev_pkg;

   localparam logic [31:0] HEX_ADDR   = 32'hF0000000;
   localparam logic [31:0] LEDR_ADDR  = 32'hF0000004;
   localparam logic [31:0] LEDG_ADDR  = 32'hF0000008;
   localparam logic [31:0] KDATA_ADDR = 32'hF0000010;
   localparam logic [31:0] KCTRL_ADDR = 32'hF0000110;

   localparam int unsigned READY_BIT = 0;
   localparam int unsigned OVR_BIT   = 2;
   localparam int unsigned IE_BIT    = 8;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, stability counter and debounced output.
// 'changed' is high in the cycle whose edge commits a new debounced value.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic clk,
   input  logic reset,
   input  logic keyN,
   output logic stable,
   output logic changed
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          pressed;
   logic [CW-1:0] cnt;

   assign pressed = ~sync2;
   assign changed = (pressed != stable) && (cnt == CNT_LAST);

   // The counter only runs while the synchronised key disagrees with the
   // accepted state, so any bounce back to the old level restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= keyN;
         sync2 <= sync1;
         if (pressed == stable) begin
            cnt <= '0;
         end else if (changed) begin
            stable <= pressed;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_device.sv
// Memory-mapped push-button device: debounced KDATA plus KCTRL status flags.
// Define KEY_IRQ_EN to add the IE bit and the registered irq output.
module key_device #(
   parameter int ABUS_WIDTH      = 32,
   parameter int DBUS_WIDTH      = 32,
   parameter int NKEYS           = 4,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter logic [ABUS_WIDTH-1:0] KDATA_ADDR = ABUS_WIDTH'(io_dev_pkg::KDATA_ADDR),
   parameter logic [ABUS_WIDTH-1:0] KCTRL_ADDR = ABUS_WIDTH'(io_dev_pkg::KCTRL_ADDR)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ABUS_WIDTH-1:0] aBus,
   inout  logic [DBUS_WIDTH-1:0] dBus,
   input  logic                  wrtEn,
   input  logic [NKEYS-1:0]      key
`ifdef KEY_IRQ_EN
   ,
   output logic                  irq
`endif
);

   import io_dev_pkg::READY_BIT, io_dev_pkg::OVR_BIT, io_dev_pkg::IE_BIT;

   logic [NKEYS-1:0]      kdata;
   logic [NKEYS-1:0]      keyChanged;
   logic                  change;
   logic                  ready;
   logic                  overrun;
   logic                  kdataRead;
   logic                  kctrlRead;
   logic                  kctrlWrite;
   logic                  clearReady;
   logic                  clearOverrun;
   logic [DBUS_WIDTH-1:0] ctrlWord;
`ifdef KEY_IRQ_EN
   logic                  ie;
`endif

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .keyN   (key[i]),
         .stable (kdata[i]),
         .changed(keyChanged[i])
      );
   end

   assign change       = |keyChanged;
   assign kdataRead    = (aBus == KDATA_ADDR) && !wrtEn;
   assign kctrlRead    = (aBus == KCTRL_ADDR) && !wrtEn;
   assign kctrlWrite   = (aBus == KCTRL_ADDR) && wrtEn;
   assign clearReady   = kdataRead || (kctrlWrite && !dBus[READY_BIT]);
   assign clearOverrun = kctrlWrite && !dBus[OVR_BIT];

   // Status word as seen by software; unimplemented bits read as zero.
   always_comb begin
      ctrlWord            = '0;
      ctrlWord[READY_BIT] = ready;
      ctrlWord[OVR_BIT]   = overrun;
`ifdef KEY_IRQ_EN
      ctrlWord[IE_BIT]    = ie;
`endif
   end

   assign dBus = kdataRead ? DBUS_WIDTH'(kdata) :
                 kctrlRead ? ctrlWord           : 'z;

   // A new key state always wins over a same-cycle clear of Ready; Overrun
   // records a change that lands while the previous one is still unread.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready   <= 1'b0;
         overrun <= 1'b0;
`ifdef KEY_IRQ_EN
         ie      <= 1'b0;
         irq     <= 1'b0;
`endif
      end else begin
         if (change) begin
            ready <= 1'b1;
         end else if (clearReady) begin
            ready <= 1'b0;
         end
         if (change && ready && !clearReady) begin
            overrun <= 1'b1;
         end else if (clearOverrun) begin
            overrun <= 1'b0;
         end
`ifdef KEY_IRQ_EN
         if (kctrlWrite) begin
            ie <= dBus[IE_BIT];
         end
         irq <= ready & ie;
`endif
      end
   end

endmodule

// File: tb/tb_key_device.sv
// Bench for key_device with DEBOUNCE_CYCLES=4: directed bus traffic, expected
// values queued at issue time and compared by an independent monitor.
module tb_key_device;

   localparam logic [31:0] KDATA = 32'hF0000010;
   localparam logic [31:0] KCTRL = 32'hF0000110;
   localparam logic [31:0] IDLE  = 32'hFFFFFFFF;

   typedef struct {
      string       name;
      logic        isIrq;
      logic [31:0] value;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] aBus = 32'h0;
   logic        wrtEn = 1'b0;
   logic [3:0]  key = 4'hF;
   logic [31:0] dBusDrv = 32'h0;
   logic        drvEn = 1'b0;
   logic        pend = 1'b0;
   logic        irqObs;
   tri1  [31:0] dBus;

   expect_t     sb[$];
   expect_t     cur;
   logic [31:0] actual;
   int          vectors = 0;
   int          miscompares = 0;

   assign dBus = drvEn ? dBusDrv : 'z;

   key_device #(
      .ABUS_WIDTH     (32),
      .DBUS_WIDTH     (32),
      .NKEYS          (4),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .aBus (aBus),
      .dBus (dBus),
      .wrtEn(wrtEn),
      .key  (key)
`ifdef KEY_IRQ_EN
      ,
      .irq  (irqObs)
`endif
   );

`ifndef KEY_IRQ_EN
   assign irqObs = 1'b0;
`endif

   always #5 clk = ~clk;

   // Monitor: whenever a sample is presented, pop the oldest expectation.
   always @(negedge clk) begin
      if (pend) begin
         if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard: sample presented with nothing expected");
         end else begin
            cur    = sb.pop_front();
            actual = cur.isIrq ? {31'b0, irqObs} : dBus;
            vectors++;
            if (actual !== cur.value)
               begin
                  miscompares++;
                  $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", cur.name, actual, cur.value);
               end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic busIdle();
      aBus  = 32'h0;
      wrtEn = 1'b0;
      drvEn = 1'b0;
   endtask

   // One-cycle bus write.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
      aBus    = addr;
      wrtEn   = 1'b1;
      dBusDrv = data;
      drvEn   = 1'b1;
      tick();
      busIdle();
   endtask

   // One-cycle bus read whose data is checked by the monitor.
   task automatic checkOutput(input logic [31:0] addr, input logic [31:0] exp, input string name);
      expect_t e;
      e.name  = name;
      e.isIrq = 1'b0;
      e.value = exp;
      sb.push_back(e);
      aBus  = addr;
      wrtEn = 1'b0;
      pend  = 1'b1;
      tick();
      pend  = 1'b0;
      busIdle();
   endtask

   task automatic checkIrq(input logic exp, input string name);
      expect_t e;
      e.name  = name;
      e.isIrq = 1'b1;
      e.value = {31'b0, exp};
      sb.push_back(e);
      pend = 1'b1;
      tick();
      pend = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state and bus isolation.
      tick(3);
      reset = 1'b0;
      checkOutput(KDATA, 32'h0, "reset_kdata");
      checkOutput(KCTRL, 32'h0, "reset_kctrl");
      checkOutput(32'h0, IDLE, "idle_no_drive");
      checkOutput(32'h10000010, IDLE, "partial_addr_no_drive");

      // Press key0: the value appears on the sixth edge after the input moves.
      key = 4'b1110;
      tick(5);
      checkOutput(KDATA, 32'h0, "latency_edge5");
      checkOutput(KCTRL, 32'h1, "ready_after_press");
      checkOutput(KDATA, 32'h1, "kdata_press");
      checkOutput(KCTRL, 32'h0, "ready_cleared_by_read");

      // Three-clock glitch on key1 must be filtered out.
      key = 4'b1100;
      tick(3);
      key = 4'b1110;
      tick(6);
      checkOutput(KDATA, 32'h1, "glitch_kdata");
      checkOutput(KCTRL, 32'h0, "glitch_ready");

      // Two unread changes produce Overrun; ones written are ignored.
      key = 4'b1111;
      tick(8);
      key = 4'b1110;
      tick(8);
      checkOutput(KCTRL, 32'h5, "overrun_set");
      applyStimulus(KCTRL, 32'h5);
      checkOutput(KCTRL, 32'h5, "write_ones_ignored");
      applyStimulus(KDATA, 32'h0);
      applyStimulus(KCTRL, 32'h0);
      checkOutput(KCTRL, 32'h0, "flags_cleared");
      checkOutput(KDATA, 32'h1, "kdata_write_ignored");

      // Debounce completing during a KDATA read, then during a KCTRL clear.
      key = 4'b1010;
      tick(5);
      checkOutput(KDATA, 32'h1, "read_coincident_old");
      checkOutput(KCTRL, 32'h1, "set_beats_read_clear");
      key = 4'b1110;
      tick(5);
      applyStimulus(KCTRL, 32'h0);
      checkOutput(KCTRL, 32'h1, "set_beats_write_clear");
      checkOutput(KDATA, 32'h1, "kdata_after_release");
      checkOutput(KCTRL, 32'h0, "ready_cleared_again");

      // Interrupt enable and irq timing.
      applyStimulus(KCTRL, 32'h100);
`ifdef KEY_IRQ_EN
      checkOutput(KCTRL, 32'h100, "ie_readback");
`else
      checkOutput(KCTRL, 32'h0, "ie_absent");
`endif
      key = 4'b1010;
      tick(6);
`ifdef KEY_IRQ_EN
      checkIrq(1'b0, "irq_lags_ready");
      checkIrq(1'b1, "irq_asserted");
`endif
      checkOutput(KDATA, 32'h5, "kdata_key2");
`ifdef KEY_IRQ_EN
      checkIrq(1'b1, "irq_lags_clear");
      checkIrq(1'b0, "irq_dropped");
`endif

      // Reset in the middle of a debounce discards the partial count.
      key = 4'b1110;
      tick(8);
      key = 4'b0110;
      tick(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput(KCTRL, 32'h0, "flags_after_reset");
      tick(3);
      checkOutput(KDATA, 32'h0, "post_reset_edge5");
      checkOutput(KDATA, 32'h0, "post_reset_edge6");
      checkOutput(KDATA, 32'h9, "post_reset_kdata");
      checkOutput(KCTRL, 32'h0, "post_reset_ready_read");
`ifdef KEY_IRQ_EN
      checkIrq(1'b0, "irq_after_reset");
`endif

      if (sb.size() != 0) begin
         miscompares += sb.size();
         $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
